// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared types and helpers for spi_cmd_sched; honours SPI_CMD_PARITY_EN
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Bits on the wire per frame: the command word, plus a trailing odd-parity bit when enabled.
    function automatic int frame_w(input int cmd_w);
`ifdef SPI_CMD_PARITY_EN
        return cmd_w + 1;
`else
        return cmd_w;
`endif
    endfunction

    // Round-robin pick: rotate req so ptr is bit 0, take the lowest set bit, rotate back.
    // With no bit set the result is ptr; callers only use it when |req.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] rot;
        logic [2:0] off;
        logic       found;
        rot   = '0;
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) rot[k] = req[3'((int'(ptr) + k) % n)];
        end
        for (int k = 0; k < 8; k++) begin
            if (!found && rot[k]) begin
                off   = 3'(k);
                found = 1'b1;
            end
        end
        return 3'((int'(ptr) + int'(off)) % n);
    endfunction

endpackage

// File: rtl/spi_cmd_sched_shifter.sv
// rtl/spi_cmd_sched_shifter.sv - MSB-first mode-0 frame shifter; appends parity under SPI_CMD_PARITY_EN
module spi_cmd_sched_shifter
    import spi_cmd_pkg::*;
#(
    parameter int CMD_W   = 16,
    parameter int CLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CMD_W-1:0] word_i,
    output logic             send_cmd_o,
    output logic             dclk_o,
    output logic             mosi_o,
    output logic             frame_done_o
);

    localparam int FRAME_W = frame_w(CMD_W);
    localparam int BW      = $clog2(FRAME_W + 1);
    localparam int DW      = $clog2(CLK_DIV + 1);

    logic [FRAME_W-1:0] frame_d;
    logic [FRAME_W-1:0] sreg_q;
    logic [BW-1:0]      bit_q;
    logic [DW-1:0]      div_q;
    logic               active_q;
    logic               dclk_q;
    logic               mosi_q;
    logic               phase_end;

`ifdef SPI_CMD_PARITY_EN
    assign frame_d = {word_i, ~^word_i};
`else
    assign frame_d = word_i;
`endif

    assign phase_end    = (div_q == DW'(CLK_DIV - 1));
    // Asserted during the cycle whose closing edge ends the last high phase.
    assign frame_done_o = active_q && dclk_q && phase_end && (bit_q == '0);

    // Load on grant, then toggle dclk every CLK_DIV cycles; the next bit goes out as dclk falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q   <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            active_q <= 1'b0;
            dclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else if (load_i) begin
            sreg_q   <= {frame_d[FRAME_W-2:0], 1'b0};
            mosi_q   <= frame_d[FRAME_W-1];
            bit_q    <= BW'(FRAME_W - 1);
            div_q    <= '0;
            dclk_q   <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (phase_end) begin
                div_q <= '0;
                if (!dclk_q) begin
                    dclk_q <= 1'b1;
                end else begin
                    dclk_q <= 1'b0;
                    if (bit_q == '0) begin
                        active_q <= 1'b0;
                        mosi_q   <= 1'b0;
                    end else begin
                        mosi_q <= sreg_q[FRAME_W-1];
                        sreg_q <= {sreg_q[FRAME_W-2:0], 1'b0};
                        bit_q  <= bit_q - 1'b1;
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign send_cmd_o = active_q;
    assign dclk_o     = dclk_q;
    assign mosi_o     = mosi_q;

endmodule

// File: rtl/spi_cmd_sched.sv
// rtl/spi_cmd_sched.sv - round-robin scheduler sharing one serial command link; SPI_CMD_PARITY_EN adds parity
module spi_cmd_sched
    import spi_cmd_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int CMD_W   = 16,
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic                   clk50m,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CMD_W-1:0] cmd_data,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   sendCmd,
    output logic                   dclk,
    output logic                   mosi
);

    localparam int GW = $clog2(GAP_CYC + 1);

    state_e           state_q;
    logic [2:0]       rr_ptr_q;
    logic [2:0]       winner_q;
    logic [GW-1:0]    gap_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;
    logic [2:0]       pick;
    logic             grant;
    logic [CMD_W-1:0] word_d;
    logic             frame_done;

    assign pick  = rr_pick(8'(req), rr_ptr_q, N_REQ);
    assign grant = (state_q == IDLE) && (|req);

    // Select the winner's command word; it is captured by the shifter only on the grant edge.
    always_comb begin
        word_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == 3'(i)) word_d = cmd_data[i*CMD_W +: CMD_W];
        end
    end

    spi_cmd_sched_shifter #(
        .CMD_W   (CMD_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i        (clk50m),
        .rst_ni       (rst_n),
        .load_i       (grant),
        .word_i       (word_d),
        .send_cmd_o   (sendCmd),
        .dclk_o       (dclk),
        .mosi_o       (mosi),
        .frame_done_o (frame_done)
    );

    // Arbiter FSM: grant, wait for the frame to end, pulse done, hold busy through the gap.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            gap_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        winner_q <= pick;
                        rr_ptr_q <= (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame_done) begin
                        for (int i = 0; i < N_REQ; i++) done_q[i] <= (winner_q == 3'(i));
                        gap_q   <= GW'(GAP_CYC - 1);
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_spi_cmd_sched.sv
// tb/tb_spi_cmd_sched.sv - directed self-checking bench for spi_cmd_sched; follows SPI_CMD_PARITY_EN
module tb_spi_cmd_sched;

`ifdef SPI_CMD_PARITY_EN
    localparam int FW = 17;
`else
    localparam int FW = 16;
`endif

    logic        clk50m = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [47:0] cmd_data;
    logic [2:0]  done;
    logic        busy;
    logic        sendCmd;
    logic        dclk;
    logic        mosi;

    int checks = 0;
    int errors = 0;

    spi_cmd_sched #(
        .N_REQ   (3),
        .CMD_W   (16),
        .CLK_DIV (2),
        .GAP_CYC (4)
    ) dut (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .req      (req),
        .cmd_data (cmd_data),
        .done     (done),
        .busy     (busy),
        .sendCmd  (sendCmd),
        .dclk     (dclk),
        .mosi     (mosi)
    );

    always #10 clk50m = ~clk50m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [15:0] w);
`ifdef SPI_CMD_PARITY_EN
        return {15'b0, w, ~^w};
`else
        return {16'b0, w};
`endif
    endfunction

    // Wait for sendCmd, count its high cycles, collect mosi at each dclk rise.
    // Returns at the first negedge with sendCmd low, where done should be pulsing.
    task automatic capture(input int drop_at, output logic [31:0] bits, output int nb,
                           output int len, output logic [2:0] done_v, output logic ok);
        int   t;
        logic prev;
        bits = '0; nb = 0; len = 0; done_v = '0; ok = 1'b0; t = 0;
        while (sendCmd !== 1'b1 && t < 2000) begin
            @(negedge clk50m);
            t++;
        end
        if (t >= 2000) return;
        prev = 1'b0;
        while (sendCmd === 1'b1 && len < 2000) begin
            if (dclk === 1'b1 && prev === 1'b0) begin
                bits = {bits[30:0], mosi};
                nb++;
                if (nb == drop_at) begin
                    req[0]         = 1'b0;
                    cmd_data[15:0] = 16'hFFFF;
                end
            end
            prev = dclk;
            len++;
            @(negedge clk50m);
        end
        done_v = done;
        ok     = (len < 2000);
    endtask

    task automatic frame_check(input string tag, input logic [15:0] w, input logic [2:0] exp_done,
                               input int drop_at);
        logic [31:0] bits;
        int          nb;
        int          len;
        logic [2:0]  dv;
        logic        ok;
        capture(drop_at, bits, nb, len, dv, ok);
        chk({tag, "_no_timeout"}, 32'(ok), 32'd1);
        chk({tag, "_bits"}, bits, exp_frame(w));
        chk({tag, "_nbits"}, nb, FW);
        chk({tag, "_sendcmd_len"}, len, FW * 4);
        chk({tag, "_done"}, 32'(dv), 32'(exp_done));
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(negedge clk50m);
            t++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk50m);
        @(negedge clk50m);
        rst_n = 1'b1;
    endtask

    initial begin
        int          t;
        int          nb;
        int          len;
        logic        prev;
        logic        ok;
        logic [31:0] bits;
        logic [2:0]  dv;
        int          order [4] = '{0, 1, 2, 0};

        rst_n    = 1'b1;
        req      = '0;
        cmd_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sendcmd", 32'(sendCmd), 32'd0);
        chk("rst_dclk", 32'(dclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        @(negedge clk50m);
        @(negedge clk50m);
        rst_n = 1'b1;
        @(negedge clk50m);

        // 1: single requester, then busy drops 4 cycles after the done pulse
        cmd_data[15:0] = 16'hA5C3;
        req = 3'b001;
        frame_check("t1", 16'hA5C3, 3'b001, -1);
        req = 3'b000;
        chk("t1_busy_e0", 32'(busy), 32'd1);
        @(negedge clk50m);
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        chk("t1_busy_e1", 32'(busy), 32'd1);
        repeat (2) @(negedge clk50m);
        chk("t1_busy_e3", 32'(busy), 32'd1);
        @(negedge clk50m);
        chk("t1_busy_e4", 32'(busy), 32'd0);

        // 2: all requesting from rr_ptr=0 -> order 0,1,2,0 with GAP_CYC+1 spacing
        do_reset();
        cmd_data = {16'h0003, 16'h0002, 16'h0001};
        req = 3'b111;
        for (int f = 0; f < 4; f++) begin
            if (f > 0) begin
                t = 0;
                while (sendCmd !== 1'b1 && t < 50) begin
                    @(negedge clk50m);
                    t++;
                end
                chk("t2_gap", t, 5);
            end
            frame_check("t2", 16'(order[f] + 1), 3'(3'b001 << order[f]), -1);
        end
        req = 3'b000;
        wait_idle("t2_idle");

        // 3: serve requester 1 (rr_ptr -> 2), then 0 must win over 1
        req = 3'b010;
        frame_check("t3_r1", 16'h0002, 3'b010, -1);
        req = 3'b000;
        wait_idle("t3_idle_a");
        req = 3'b011;
        frame_check("t3_first", 16'h0001, 3'b001, -1);
        req = 3'b010;
        frame_check("t3_second", 16'h0002, 3'b010, -1);
        req = 3'b000;
        wait_idle("t3_idle_b");

        // 4: reset at bit 7 aborts the frame; held request restarts from the MSB
        cmd_data[15:0] = 16'hA5C3;
        req = 3'b001;
        t = 0; nb = 0; prev = 1'b0;
        while (nb < 7 && t < 1000) begin
            @(negedge clk50m);
            if (dclk === 1'b1 && prev === 1'b0) nb++;
            prev = dclk;
            t++;
        end
        chk("t4_reached_bit7", nb, 7);
        rst_n = 1'b0;
        #1;
        chk("t4_sendcmd", 32'(sendCmd), 32'd0);
        chk("t4_dclk", 32'(dclk), 32'd0);
        chk("t4_mosi", 32'(mosi), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        @(negedge clk50m);
        rst_n = 1'b1;
        frame_check("t4_restart", 16'hA5C3, 3'b001, -1);
        req = 3'b000;
        wait_idle("t4_idle");

        // 5: drop req and corrupt data mid-frame; original word still completes
        cmd_data[15:0] = 16'h3C5A;
        req = 3'b001;
        frame_check("t5", 16'h3C5A, 3'b001, 3);
        repeat (20) @(negedge clk50m);
        chk("t5_no_refire_sendcmd", 32'(sendCmd), 32'd0);
        chk("t5_no_refire_busy", 32'(busy), 32'd0);

        // 6: word 0x0007, with or without trailing parity bit
        cmd_data[15:0] = 16'h0007;
        req = 3'b001;
        capture(-1, bits, nb, len, dv, ok);
        req = 3'b000;
        chk("t6_no_timeout", 32'(ok), 32'd1);
`ifdef SPI_CMD_PARITY_EN
        chk("t6_bits", bits, 32'h0000_000E);
        chk("t6_nbits", nb, 17);
        chk("t6_last_bit", 32'(bits[0]), 32'd0);
        chk("t6_sendcmd_len", len, 68);
`else
        chk("t6_bits", bits, 32'h0000_0007);
        chk("t6_nbits", nb, 16);
        chk("t6_last_bit", 32'(bits[0]), 32'd1);
        chk("t6_sendcmd_len", len, 64);
`endif
        chk("t6_done", 32'(dv), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
